// File: rtl/fa_response_checker.sv
// fa_response_checker: full-adder response monitor with latency alignment,
// saturating statistics, input-space coverage and a pass/fail verdict.
module fa_response_checker #(
    parameter int LATENCY = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             stim_valid,
    input  logic             stim_a,
    input  logic             stim_b,
    input  logic             stim_cin,
    input  logic             rsp_sum,
    input  logic             rsp_carry,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       coverage,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid,
    output logic [1:0]       status
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PASS = 2'd2, FAIL = 2'd3} state_t;
    typedef struct packed {
        logic       valid;
        logic [2:0] vec;
        logic       sum;
        logic       carry;
    } tuple_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    tuple_t stim_t, algn;
    state_t state, state_nx;
    logic   miss, cmp_done;
    always_comb begin
        stim_t.valid = stim_valid;
        stim_t.vec   = {stim_a, stim_b, stim_cin};
        stim_t.sum   = stim_a ^ stim_b ^ stim_cin;
        stim_t.carry = (stim_a & stim_b) | (stim_cin & (stim_a ^ stim_b));
    end
    generate
        if (LATENCY == 0) begin : g_direct
            assign algn = stim_t;
        end else begin : g_pipe
            tuple_t pipe [LATENCY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= stim_t;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign algn = pipe[LATENCY-1];
        end
    endgenerate
    // case inequality so an X/Z response on an aligned compare is a miss
    assign miss = algn.valid && ({rsp_sum, rsp_carry} !== {algn.sum, algn.carry});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cmp_done, mismatch, vec_count, err_count, coverage, first_err_vec, first_err_valid} <= '0;
        end else if (clear) begin
            {cmp_done, mismatch, vec_count, err_count, coverage, first_err_vec, first_err_valid} <= '0;
        end else begin
            cmp_done <= algn.valid;
            mismatch <= miss;
            if (algn.valid) begin
                if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
                coverage[algn.vec] <= 1'b1;
            end
            if (miss) begin
                if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                if (!first_err_valid) begin
                    first_err_vec   <= algn.vec;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (clear) state <= IDLE;
        else state <= state_nx;
    end
    // verdict follows the registered statistics, so it trails them by one cycle
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = cmp_done ? RUN : IDLE;
        else if (state != FAIL) state_nx = (err_count != '0) ? FAIL : (coverage == 8'hFF) ? PASS : state;
    end
    assign status = state;
endmodule

// File: tb/tb_fa_response_checker.sv
// tb_fa_response_checker: drives three checker instances (latency 0, latency 2,
// latency 0 with 3-bit counters) from one stimulus stream against a scoreboard.
module tb_fa_response_checker;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PASS = 2'd2, S_FAIL = 2'd3;
    typedef struct {
        bit         v;
        logic [2:0] vec;
        bit         bad;
    } ev_t;

    logic clk = 0, rst_n = 0, clear = 0, stim_valid = 0, a = 0, b = 0, cin = 0;
    logic f_sum = 0, f_carry = 0, g_sum = 0, g_carry = 0;
    logic [1:0] add_out;
    logic rsp0_sum, rsp0_carry, r1_sum, r1_carry, r2_sum, r2_carry;
    logic m0, m2, ms, fevl0, fevl2, fevls;
    logic [15:0] vc0, ec0, vc2, ec2;
    logic [2:0] vcs, ecs, fev0, fev2, fevs;
    logic [7:0] cov0, cov2, covs;
    logic [1:0] st0, st2, sts;

    int compared = 0, mismatched = 0;
    int pulses0 = 0, pulses2 = 0;
    int n[2], e[2];
    logic [7:0] cov[2];
    logic [2:0] fev[2];
    bit fe[2], last_bad[2];
    ev_t q2[$];

    always #5 clk = ~clk;

    // reference adder from plain arithmetic, faults flip bits, garbage when idle
    assign add_out = 2'(a) + 2'(b) + 2'(cin);
    assign rsp0_sum = stim_valid ? add_out[0] ^ f_sum : g_sum;
    assign rsp0_carry = stim_valid ? add_out[1] ^ f_carry : g_carry;
    always @(posedge clk) begin
        r1_sum <= rsp0_sum; r1_carry <= rsp0_carry;
        r2_sum <= r1_sum; r2_carry <= r1_carry;
    end

    always @(negedge clk) if (rst_n) begin
        pulses0 += int'(m0);
        pulses2 += int'(m2);
    end

    fa_response_checker #(.LATENCY(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .stim_valid(stim_valid),
        .stim_a(a), .stim_b(b), .stim_cin(cin), .rsp_sum(rsp0_sum), .rsp_carry(rsp0_carry),
        .mismatch(m0), .vec_count(vc0), .err_count(ec0), .coverage(cov0),
        .first_err_vec(fev0), .first_err_valid(fevl0), .status(st0));
    fa_response_checker #(.LATENCY(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .stim_valid(stim_valid),
        .stim_a(a), .stim_b(b), .stim_cin(cin), .rsp_sum(r2_sum), .rsp_carry(r2_carry),
        .mismatch(m2), .vec_count(vc2), .err_count(ec2), .coverage(cov2),
        .first_err_vec(fev2), .first_err_valid(fevl2), .status(st2));
    fa_response_checker #(.LATENCY(0), .CNT_W(3)) us (
        .clk(clk), .rst_n(rst_n), .clear(clear), .stim_valid(stim_valid),
        .stim_a(a), .stim_b(b), .stim_cin(cin), .rsp_sum(rsp0_sum), .rsp_carry(rsp0_carry),
        .mismatch(ms), .vec_count(vcs), .err_count(ecs), .coverage(covs),
        .first_err_vec(fevs), .first_err_valid(fevls), .status(sts));

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            n[m] = 0; e[m] = 0; cov[m] = '0; fev[m] = '0; fe[m] = 0; last_bad[m] = 0;
        end
        q2.delete();
    endfunction

    function automatic void account(int m, ev_t x);
        last_bad[m] = x.bad;
        if (x.v) begin
            n[m]++;
            cov[m][x.vec] = 1'b1;
        end
        if (x.bad) begin
            e[m]++;
            if (!fe[m]) begin fe[m] = 1; fev[m] = x.vec; end
        end
    endfunction

    function automatic int sat(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    // verdict implied by the accumulated statistics once the pipeline is quiet
    function automatic logic [1:0] exp_status(int m);
        return e[m] > 0 ? S_FAIL : cov[m] == 8'hFF ? S_PASS : n[m] > 0 ? S_RUN : S_IDLE;
    endfunction

    // one clock: drive at the falling edge, return just after the rising edge
    task automatic step(input bit v, input logic [2:0] vec, input bit fs, input bit fc, input bit clr);
        ev_t x;
        @(negedge clk);
        stim_valid = v; {a, b, cin} = vec; f_sum = fs; f_carry = fc; clear = clr;
        g_sum = 1'($urandom); g_carry = 1'($urandom);
        x = '{v: v, vec: vec, bad: v && (fs || fc)};
        if (clr) model_clear();
        else begin
            account(0, x);
            q2.push_back(x);
            if (q2.size() > 2) account(1, q2.pop_front());
            else last_bad[1] = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic flush(input int cycles);
        repeat (cycles) step(0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_reset;
        model_clear();
        repeat (2) @(negedge clk);
        compared++; if (vc0 !== 16'd0 || ec0 !== 16'd0) begin mismatched++; $display("FAIL reset_counts: got %0d/%0d want 0/0", vc0, ec0); end
        compared++; if (cov0 !== 8'h00 || fevl0 !== 1'b0 || fev0 !== 3'd0) begin mismatched++; $display("FAIL reset_cov: got %h/%b/%0d want 00/0/0", cov0, fevl0, fev0); end
        compared++; if (st0 !== S_IDLE || st2 !== S_IDLE || m0 !== 1'b0) begin mismatched++; $display("FAIL reset_status: got %0d/%0d mm=%b want 0/0 mm=0", st0, st2, m0); end
        rst_n = 1;
    endtask

    task automatic test_pass;
        pulses0 = 0; pulses2 = 0;
        for (int i = 0; i < 4; i++) step(1, 3'(i), 0, 0, 0);
        flush(4);
        compared++; if (st0 !== S_RUN || st2 !== S_RUN) begin mismatched++; $display("FAIL pass_run: got %0d/%0d want %0d", st0, st2, S_RUN); end
        for (int i = 4; i < 8; i++) step(1, 3'(i), 0, 0, 0);
        flush(4);
        compared++; if (vc0 !== 16'd8 || ec0 !== 16'd0) begin mismatched++; $display("FAIL pass_counts: got %0d/%0d want 8/0", vc0, ec0); end
        compared++; if (cov0 !== 8'hFF || cov2 !== 8'hFF) begin mismatched++; $display("FAIL pass_cov: got %h/%h want ff/ff", cov0, cov2); end
        compared++; if (st0 !== S_PASS || st2 !== S_PASS || sts !== S_PASS) begin mismatched++; $display("FAIL pass_status: got %0d/%0d/%0d want 2", st0, st2, sts); end
        compared++; if (vcs !== 3'd7) begin mismatched++; $display("FAIL pass_sat: got %0d want 7", vcs); end
        compared++; if (pulses0 != 0 || pulses2 != 0 || fevl0 !== 1'b0) begin mismatched++; $display("FAIL pass_nomiss: got %0d/%0d fe=%b want 0/0 fe=0", pulses0, pulses2, fevl0); end
    endtask

    task automatic test_gaps;
        step(0, 3'd0, 0, 0, 1);
        pulses2 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 3'(i), 0, 0, 0);
            compared++; if (vc2 !== 16'(n[1])) begin mismatched++; $display("FAIL gap_cnt_v%0d: got %0d want %0d", i, vc2, n[1]); end
            step(0, 3'd0, 0, 0, 0);
            compared++; if (vc2 !== 16'(n[1]) || m2 !== 1'b0) begin mismatched++; $display("FAIL gap_cnt_g%0d: got %0d mm=%b want %0d mm=0", i, vc2, m2, n[1]); end
        end
        flush(4);
        compared++; if (vc2 !== 16'd8 || ec2 !== 16'd0 || cov2 !== 8'hFF) begin mismatched++; $display("FAIL gap_final: got %0d/%0d/%h want 8/0/ff", vc2, ec2, cov2); end
        compared++; if (st2 !== S_PASS || pulses2 != 0) begin mismatched++; $display("FAIL gap_status: got %0d pulses=%0d want 2 pulses=0", st2, pulses2); end
    endtask

    task automatic test_fault;
        step(0, 3'd0, 0, 0, 1);
        pulses0 = 0; pulses2 = 0;
        for (int i = 0; i < 8; i++) step(1, 3'(i), 0, i == 3, 0);
        flush(4);
        compared++; if (pulses0 != 1 || pulses2 != 1) begin mismatched++; $display("FAIL fault_pulse: got %0d/%0d want 1/1", pulses0, pulses2); end
        compared++; if (ec0 !== 16'd1 || ec2 !== 16'd1) begin mismatched++; $display("FAIL fault_err: got %0d/%0d want 1/1", ec0, ec2); end
        compared++; if (fev0 !== 3'b011 || fev2 !== 3'b011 || fevl0 !== 1'b1) begin mismatched++; $display("FAIL fault_first: got %b/%b v=%b want 011/011 v=1", fev0, fev2, fevl0); end
        compared++; if (st0 !== S_FAIL || st2 !== S_FAIL) begin mismatched++; $display("FAIL fault_status: got %0d/%0d want 3", st0, st2); end
        step(1, 3'b111, 1, 0, 0);
        flush(4);
        compared++; if (fev0 !== 3'b011 || fev2 !== 3'b011 || ec0 !== 16'd2 || pulses0 != 2) begin mismatched++; $display("FAIL fault_second: got %b/%b err=%0d p=%0d want 011/011 err=2 p=2", fev0, fev2, ec0, pulses0); end
    endtask

    task automatic test_clear;
        for (int i = 1; i < 5; i++) step(1, 3'(i), 0, 0, 0);
        step(1, 3'd5, 0, 0, 1);
        compared++; if (vc2 !== 16'd0 || cov2 !== 8'h00 || ec2 !== 16'd0 || fevl2 !== 1'b0) begin mismatched++; $display("FAIL clear_now: got %0d/%h/%0d/%b want 0/00/0/0", vc2, cov2, ec2, fevl2); end
        compared++; if (st2 !== S_IDLE || st0 !== S_IDLE || vc0 !== 16'd0) begin mismatched++; $display("FAIL clear_status: got %0d/%0d cnt=%0d want 0/0 cnt=0", st2, st0, vc0); end
        flush(5);
        compared++; if (vc2 !== 16'd0 || cov2 !== 8'h00 || st2 !== S_IDLE) begin mismatched++; $display("FAIL clear_inflight: got %0d/%h/%0d want 0/00/0", vc2, cov2, st2); end
    endtask

    task automatic test_saturation;
        step(0, 3'd0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 3'(i), 0, 0, 0);
        flush(4);
        compared++; if (vcs !== 3'd7 || vc0 !== 16'd9 || ecs !== 3'd0) begin mismatched++; $display("FAIL sat_count: got %0d/%0d/%0d want 7/9/0", vcs, vc0, ecs); end
        compared++; if (sts !== S_PASS) begin mismatched++; $display("FAIL sat_status: got %0d want 2", sts); end
    endtask

    task automatic test_random;
        step(0, 3'd0, 0, 0, 1);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) < 75, 3'($urandom), $urandom_range(99) < 5,
                 $urandom_range(99) < 5, $urandom_range(99) < 2);
            compared++; if (vc0 !== 16'(n[0]) || ec0 !== 16'(e[0]) || cov0 !== cov[0] || m0 !== last_bad[0]) begin mismatched++; $display("FAIL rnd_l0_c%0d: got %0d/%0d/%h/%b want %0d/%0d/%h/%b", c, vc0, ec0, cov0, m0, n[0], e[0], cov[0], last_bad[0]); end
            compared++; if (vc2 !== 16'(n[1]) || ec2 !== 16'(e[1]) || cov2 !== cov[1] || m2 !== last_bad[1]) begin mismatched++; $display("FAIL rnd_l2_c%0d: got %0d/%0d/%h/%b want %0d/%0d/%h/%b", c, vc2, ec2, cov2, m2, n[1], e[1], cov[1], last_bad[1]); end
            compared++; if (fevl0 !== fe[0] || fev0 !== fev[0] || fevl2 !== fe[1] || fev2 !== fev[1]) begin mismatched++; $display("FAIL rnd_first_c%0d: got %b%0d/%b%0d want %b%0d/%b%0d", c, fevl0, fev0, fevl2, fev2, fe[0], fev[0], fe[1], fev[1]); end
            compared++; if (vcs !== 3'(sat(n[0], 7)) || ecs !== 3'(sat(e[0], 7))) begin mismatched++; $display("FAIL rnd_sat_c%0d: got %0d/%0d want %0d/%0d", c, vcs, ecs, sat(n[0], 7), sat(e[0], 7)); end
        end
        flush(4);
        compared++; if (st0 !== exp_status(0) || st2 !== exp_status(1) || sts !== exp_status(0)) begin mismatched++; $display("FAIL rnd_status: got %0d/%0d/%0d want %0d/%0d", st0, st2, sts, exp_status(0), exp_status(1)); end
    endtask

    task automatic test_async_reset;
        step(1, 3'b101, 1, 0, 0);
        flush(4);
        compared++; if (st0 !== S_FAIL || st2 !== S_FAIL) begin mismatched++; $display("FAIL ares_pre: got %0d/%0d want 3", st0, st2); end
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        compared++; if (vc0 !== 16'd0 || ec0 !== 16'd0 || cov0 !== 8'h00 || vc2 !== 16'd0 || ec2 !== 16'd0) begin mismatched++; $display("FAIL ares_counts: got %0d/%0d/%h/%0d/%0d want 0", vc0, ec0, cov0, vc2, ec2); end
        compared++; if (st0 !== S_IDLE || st2 !== S_IDLE || fevl0 !== 1'b0 || fev0 !== 3'd0 || m0 !== 1'b0) begin mismatched++; $display("FAIL ares_state: got %0d/%0d/%b/%0d/%b want 0", st0, st2, fevl0, fev0, m0); end
        model_clear();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_pass;
        test_gaps;
        test_fault;
        test_clear;
        test_saturation;
        test_random;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
